// File: rtl/img_pkg.sv
// Shared image-geometry defaults, derived widths and FSM encoding for the
// binary-image reduction stages.
package img_pkg;

    localparam int DEF_IMG_W     = 320;
    localparam int DEF_IMG_H     = 240;
    localparam int DEF_MIN_COUNT = 16;

    localparam int DEF_XW = $clog2(DEF_IMG_W);
    localparam int DEF_YW = $clog2(DEF_IMG_H);
    localparam int DEF_CW = $clog2(DEF_IMG_W * DEF_IMG_H + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    // The threshold stage only emits 8'h00 / 8'hFF, so the MSB carries the decision.
    function automatic logic is_white(input logic [7:0] px);
        return px[7];
    endfunction

endpackage

// File: rtl/binary_bbox_extractor_if.sv
// Pixel-in / bounding-box-out bundle between the threshold stage and the
// bounding-box extractor.
interface binary_bbox_extractor_if
    import img_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W * IMG_H + 1);

    logic [7:0]    pixel_in;
    logic          pixel_valid;
    logic          sof;
    logic          bbox_valid;
    logic          bbox_found;
    logic [XW-1:0] bbox_xmin;
    logic [XW-1:0] bbox_xmax;
    logic [YW-1:0] bbox_ymin;
    logic [YW-1:0] bbox_ymax;
    logic [CW-1:0] bbox_count;
    logic          frame_err;

    modport master (
        output pixel_in, pixel_valid, sof,
        input  bbox_valid, bbox_found, bbox_xmin, bbox_xmax,
               bbox_ymin, bbox_ymax, bbox_count, frame_err
    );

    modport slave (
        input  pixel_in, pixel_valid, sof,
        output bbox_valid, bbox_found, bbox_xmin, bbox_xmax,
               bbox_ymin, bbox_ymax, bbox_count, frame_err
    );

endinterface

// File: rtl/pixel_coord_counter.sv
// Raster x/y position tracker: cur_x/cur_y give the coordinate of the pixel
// presented this cycle, restart forces it to (0,0).
module pixel_coord_counter
    import img_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int XW    = $clog2(IMG_W),
    parameter int YW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv,
    input  logic          restart,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic          last_pixel
);

    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;
    logic          eol_s;

    // Coordinate of the pixel on the bus this cycle.
    always_comb begin
        cur_x = x_r;
        cur_y = y_r;
        if (restart) begin
            cur_x = {XW{1'b0}};
            cur_y = {YW{1'b0}};
        end else begin
            cur_x = x_r;
            cur_y = y_r;
        end
        eol_s      = (cur_x == XW'(IMG_W - 1));
        last_pixel = eol_s && (cur_y == YW'(IMG_H - 1));
    end

    // Next expected position; freezes while adv is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_r <= {XW{1'b0}};
            y_r <= {YW{1'b0}};
        end else if (adv) begin
            if (last_pixel) begin
                x_r <= {XW{1'b0}};
                y_r <= {YW{1'b0}};
            end else if (eol_s) begin
                x_r <= {XW{1'b0}};
                y_r <= cur_y + YW'(1);
            end else begin
                x_r <= cur_x + XW'(1);
                y_r <= cur_y;
            end
        end else begin
            x_r <= x_r;
            y_r <= y_r;
        end
    end

endmodule

// File: rtl/binary_bbox_extractor.sv
// Reduces each binary frame to the bounding box of its white pixels plus a
// white-pixel count, reported as a one-cycle strobe after the last pixel.
module binary_bbox_extractor
    import img_pkg::*;
#(
    parameter int IMG_W     = DEF_IMG_W,
    parameter int IMG_H     = DEF_IMG_H,
    parameter int MIN_COUNT = DEF_MIN_COUNT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    binary_bbox_extractor_if.slave  bus
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W * IMG_H + 1);

    logic [1:0]    state_r, state_nxt_s;
    logic          take_s, restart_s, early_s, done_s, white_s, found_s;
    logic [XW-1:0] cur_x_s;
    logic [YW-1:0] cur_y_s;
    logic          last_s;

    logic          seen_r, seen_nxt_s;
    logic [XW-1:0] xmin_r, xmax_r, xmin_nxt_s, xmax_nxt_s;
    logic [YW-1:0] ymin_r, ymax_r, ymin_nxt_s, ymax_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic          err_r;

    logic          bbox_valid_r, bbox_found_r, frame_err_r;
    logic [XW-1:0] bbox_xmin_r, bbox_xmax_r;
    logic [YW-1:0] bbox_ymin_r, bbox_ymax_r;
    logic [CW-1:0] bbox_count_r;

    // Any sof with a valid pixel starts a frame; inside ACTIVE it is an early restart.
    assign restart_s = bus.pixel_valid && bus.sof;
    assign take_s    = bus.pixel_valid && (bus.sof || (state_r == ST_ACTIVE));
    assign early_s   = restart_s && (state_r == ST_ACTIVE);
    assign done_s    = take_s && last_s;
    assign white_s   = is_white(bus.pixel_in);

    pixel_coord_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .XW    (XW),
        .YW    (YW)
    ) u_coord (
        .clk        (clk),
        .rst_n      (rst_n),
        .adv        (take_s),
        .restart    (restart_s),
        .cur_x      (cur_x_s),
        .cur_y      (cur_y_s),
        .last_pixel (last_s)
    );

    // Frame state transitions.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE, ST_REPORT: begin
                if (take_s) state_nxt_s = last_s ? ST_REPORT : ST_ACTIVE;
                else        state_nxt_s = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (done_s) state_nxt_s = ST_REPORT;
                else        state_nxt_s = ST_ACTIVE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Accumulator update including the current pixel; a restart discards old totals.
    always_comb begin
        seen_nxt_s = restart_s ? 1'b0 : seen_r;
        xmin_nxt_s = restart_s ? {XW{1'b0}} : xmin_r;
        xmax_nxt_s = restart_s ? {XW{1'b0}} : xmax_r;
        ymin_nxt_s = restart_s ? {YW{1'b0}} : ymin_r;
        ymax_nxt_s = restart_s ? {YW{1'b0}} : ymax_r;
        cnt_nxt_s  = restart_s ? {CW{1'b0}} : cnt_r;
        if (white_s) begin
            if (!seen_nxt_s) begin
                xmin_nxt_s = cur_x_s;
                xmax_nxt_s = cur_x_s;
                ymin_nxt_s = cur_y_s;
                ymax_nxt_s = cur_y_s;
            end else begin
                if (cur_x_s < xmin_nxt_s) xmin_nxt_s = cur_x_s;
                else                      xmin_nxt_s = xmin_nxt_s;
                if (cur_x_s > xmax_nxt_s) xmax_nxt_s = cur_x_s;
                else                      xmax_nxt_s = xmax_nxt_s;
                if (cur_y_s < ymin_nxt_s) ymin_nxt_s = cur_y_s;
                else                      ymin_nxt_s = ymin_nxt_s;
                if (cur_y_s > ymax_nxt_s) ymax_nxt_s = cur_y_s;
                else                      ymax_nxt_s = ymax_nxt_s;
            end
            seen_nxt_s = 1'b1;
            cnt_nxt_s  = cnt_nxt_s + CW'(1);
        end else begin
            seen_nxt_s = seen_nxt_s;
        end
        found_s = (cnt_nxt_s >= CW'(MIN_COUNT));
    end

    // State, accumulators and the truncated-frame flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            seen_r  <= 1'b0;
            xmin_r  <= {XW{1'b0}};
            xmax_r  <= {XW{1'b0}};
            ymin_r  <= {YW{1'b0}};
            ymax_r  <= {YW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (take_s) begin
                seen_r <= seen_nxt_s;
                xmin_r <= xmin_nxt_s;
                xmax_r <= xmax_nxt_s;
                ymin_r <= ymin_nxt_s;
                ymax_r <= ymax_nxt_s;
                cnt_r  <= cnt_nxt_s;
            end
            if (done_s)       err_r <= 1'b0;
            else if (early_s) err_r <= 1'b1;
            else              err_r <= err_r;
        end
    end

    // Result registers: loaded on the last pixel, held until the next frame ends.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bbox_valid_r <= 1'b0;
            bbox_found_r <= 1'b0;
            bbox_xmin_r  <= {XW{1'b0}};
            bbox_xmax_r  <= {XW{1'b0}};
            bbox_ymin_r  <= {YW{1'b0}};
            bbox_ymax_r  <= {YW{1'b0}};
            bbox_count_r <= {CW{1'b0}};
            frame_err_r  <= 1'b0;
        end else begin
            bbox_valid_r <= done_s;
            if (done_s) begin
                bbox_found_r <= found_s;
                bbox_xmin_r  <= found_s ? xmin_nxt_s : {XW{1'b0}};
                bbox_xmax_r  <= found_s ? xmax_nxt_s : {XW{1'b0}};
                bbox_ymin_r  <= found_s ? ymin_nxt_s : {YW{1'b0}};
                bbox_ymax_r  <= found_s ? ymax_nxt_s : {YW{1'b0}};
                bbox_count_r <= cnt_nxt_s;
                frame_err_r  <= err_r;
            end
        end
    end

    assign bus.bbox_valid = bbox_valid_r;
    assign bus.bbox_found = bbox_found_r;
    assign bus.bbox_xmin  = bbox_xmin_r;
    assign bus.bbox_xmax  = bbox_xmax_r;
    assign bus.bbox_ymin  = bbox_ymin_r;
    assign bus.bbox_ymax  = bbox_ymax_r;
    assign bus.bbox_count = bbox_count_r;
    assign bus.frame_err  = frame_err_r;

endmodule
